// File: rtl/instr_mem_responder.sv
// rtl/instr_mem_responder.sv - direct-mapped one-word-per-line instruction cache responder
//
// Ports:
//   iClk, iRst_n          clock; asynchronous active-low reset
//   iInstrMemAddress      fetch word address, held by the requester until oInstrMemReady
//   iInstrMemValid        fetch request present
//   iFlush                invalidate every line (takes effect the following cycle)
//   oInstrMemData         returned instruction word, holds its value between responses
//   oInstrMemReady        single-cycle response strobe
//   oMemAddr, oMemRead    backing-memory read request, held until iMemAck
//   iMemData, iMemAck     backing-memory read data and one-cycle completion
//   oHitCount, oMissCount wrapping request statistics
module instr_mem_responder #(
  parameter int INDEX_BITS = 3,
  parameter int CNT_W      = 16
) (
  input  logic             iClk,
  input  logic             iRst_n,
  input  logic [31:0]      iInstrMemAddress,
  input  logic             iInstrMemValid,
  input  logic             iFlush,
  output logic [31:0]      oInstrMemData,
  output logic             oInstrMemReady,
  output logic [31:0]      oMemAddr,
  output logic             oMemRead,
  input  logic [31:0]      iMemData,
  input  logic             iMemAck,
  output logic [CNT_W-1:0] oHitCount,
  output logic [CNT_W-1:0] oMissCount
);

  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = 32 - INDEX_BITS;

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    WAIT_MEM = 1'b1
  } state_t;

  state_t state;
  state_t stateNext;

  logic [LINES-1:0] validBits;
  logic [TAG_W-1:0] tagMem  [LINES];
  logic [31:0]      dataMem [LINES];

  // Remembers a flush seen while the refill was outstanding, so the
  // fetched word is returned but never installed as a stale line.
  logic flushSeen;

  logic [INDEX_BITS-1:0] reqIndex;
  logic [TAG_W-1:0]      reqTag;
  logic [INDEX_BITS-1:0] fillIndex;
  logic [TAG_W-1:0]      fillTag;
  logic                  accept;
  logic                  lineHit;
  logic                  hit;
  logic                  miss;
  logic                  ackTake;
  logic                  install;

  assign reqIndex  = iInstrMemAddress[INDEX_BITS-1:0];
  assign reqTag    = iInstrMemAddress[31:INDEX_BITS];
  // The refill address is the latched request, so install uses oMemAddr.
  assign fillIndex = oMemAddr[INDEX_BITS-1:0];
  assign fillTag   = oMemAddr[31:INDEX_BITS];

  // Blocking on oInstrMemReady stops a held request from being re-accepted
  // in its own response cycle, which limits throughput to one per 2 cycles.
  assign accept  = (state == IDLE) && iInstrMemValid && !oInstrMemReady;
  assign lineHit = validBits[reqIndex] && (tagMem[reqIndex] == reqTag) && !iFlush;
  assign hit     = accept && lineHit;
  assign miss    = accept && !lineHit;
  assign ackTake = (state == WAIT_MEM) && iMemAck;
  assign install = ackTake && !flushSeen && !iFlush;

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:     if (miss) stateNext = WAIT_MEM;
      WAIT_MEM: if (iMemAck) stateNext = IDLE;
      default:  stateNext = IDLE;
    endcase
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      validBits      <= '0;
      oInstrMemReady <= 1'b0;
      oInstrMemData  <= '0;
      oMemRead       <= 1'b0;
      oMemAddr       <= '0;
      oHitCount      <= '0;
      oMissCount     <= '0;
      flushSeen      <= 1'b0;
    end else begin
      oInstrMemReady <= 1'b0;

      if (hit) begin
        oInstrMemReady <= 1'b1;
        oInstrMemData  <= dataMem[reqIndex];
        oHitCount      <= oHitCount + 1'b1;
      end

      if (miss) begin
        oMemAddr   <= iInstrMemAddress;
        oMemRead   <= 1'b1;
        oMissCount <= oMissCount + 1'b1;
        flushSeen  <= 1'b0;
      end

      if (state == WAIT_MEM) begin
        if (iFlush) begin
          flushSeen <= 1'b1;
        end
        if (iMemAck) begin
          oMemRead       <= 1'b0;
          oInstrMemReady <= 1'b1;
          oInstrMemData  <= iMemData;
        end
      end

      if (iFlush) begin
        validBits <= '0;
      end else if (install) begin
        validBits[fillIndex] <= 1'b1;
      end
    end
  end

  // Tag and data arrays are deliberately unreset; validBits alone define contents.
  always_ff @(posedge iClk) begin
    if (install) begin
      tagMem[fillIndex]  <= fillTag;
      dataMem[fillIndex] <= iMemData;
    end
  end

endmodule
